rv_alu_exec: RTL and testbench
==============================

# rv_alu_exec

Single-cycle ALU execute stage directly downstream of `rv_alu_decode`. It consumes the one-hot decode flags (`is_add`/`is_sub`/`is_and`/`is_or`) together with register operands and destination index, computes the result, and presents it to writeback through a registered valid/ready output. A two-entry skid buffer keeps `in_ready` registered. A wrapping retired-op counter supports performance monitoring.

## Interface
- `XLEN`, 32: operand/result width.
- `CNT_W`, 16: retired-op counter width.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `flush` input 1: synchronous pipeline kill. Drops all buffered entries.
- `in_valid` input 1: upstream entry valid. This is the decoder's `valid` qualified by fetch.
- `in_ready` output 1: stage can accept. Driven straight from a flop.
- `is_add`, `is_sub`, `is_and`, `is_or` input 1 each: decode flags.
- `rs1_val`, `rs2_val` input XLEN: operands.
- `rd_addr` input 5: destination register.
- `out_valid` output 1: result valid.
- `out_ready` input 1: writeback accepts.
- `out_result` output XLEN: ALU result.
- `out_rd` output 5: destination register, passed through from `rd_addr`.
- `out_illegal` output 1: flags were not exactly one-hot.
- `retired_cnt` output CNT_W: count of output handshakes with `out_illegal=0`.

## Operation
- Accept occurs when `in_valid & in_ready`. Emit occurs when `out_valid & out_ready`.
- The result is computed combinationally from the inputs at accept time and stored with `rd` and `illegal`. Operands are not stored.
- ADD: `rs1+rs2` mod 2^XLEN.
- SUB: `rs1-rs2` mod 2^XLEN. No overflow or carry flag.
- AND: `rs1&rs2`.
- OR: `rs1|rs2`.
- If zero flags or more than one flag is asserted: `illegal=1` and `result=0`. `rd` still passes through.
- Storage is an output register (main) plus a skid register.
- States, encoded by {main_v, skid_v}:
  - EMPTY {0,0}
  - ONE {1,0}
  - FULL {1,1}
- Transitions:
  - EMPTY, accept → ONE. Entry goes to main.
  - ONE, accept & emit → ONE. Main reloads with the new entry.
  - ONE, accept & !emit → FULL. Entry goes to skid.
  - ONE, !accept & emit → EMPTY.
  - FULL, emit → ONE. Skid moves to main.
  - FULL, accept is impossible because `in_ready=0`.
- `in_ready` is the registered value of `!skid_v` as of the next cycle.
- `out_valid = main_v`. `out_result`, `out_rd` and `out_illegal` come from the main register.
- Ordering is strict FIFO. No entry is dropped or duplicated except by `flush` or `rst`.
- `retired_cnt` increments by 1 on each emit with `out_illegal=0`. It wraps from 2^CNT_W−1 to 0.
- `flush` clears main_v and skid_v next cycle and ignores the same-cycle accept and emit. `retired_cnt` is not cleared and does not count an emit coincident with `flush`.

## Timing
- Latency: an accept in cycle N gives `out_valid` in cycle N+1 if the stage was empty or the main entry emitted in cycle N.
- Throughput: 1 op/cycle while `out_ready=1`.
- Backpressure: at most 2 entries are held. `in_ready` falls the cycle after the second entry is stored.
- Reset values: `in_ready=1`, `out_valid=0`, `out_result=0`, `out_rd=0`, `out_illegal=0`, `retired_cnt=0`.
- Simultaneous `rst` and `flush`: `rst` wins.
- `rst` mid-operation discards all entries, with no emit in that cycle.
- Data outputs only change when main loads. They hold stable while `out_valid & !out_ready`.
- Data outputs are don't-care but deterministic while `out_valid=0`. They keep their last value.

## Structure
- Package `rv_alu_pkg`:
  - `XLEN_DEFAULT`.
  - Enum `alu_op_e` {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_ILLEGAL}.
  - Packed struct `alu_entry_t` {result, rd, illegal}.
  - Function `flags_to_op`, which implements the one-hot check.
- Sub-module `rv_skid_buffer #(type T)` holds the generic two-entry valid/ready storage.
- `rv_alu_exec` contains the op decode, the ALU datapath, the counter and the skid-buffer instance.

## Test plan
- Reset, then `is_add`, rs1=0xFFFF_FFFF, rs2=1, rd=5, `out_ready=1` → next cycle `out_valid=1`, result=0x0, rd=5, illegal=0, `retired_cnt=1`.
- `is_sub` with rs1=3, rs2=5, followed by `is_and` 0xF0F0_F0F0 & 0x0FF0_0FF0, then `is_or` 0xA & 0x5 → results 0xFFFF_FFFE, 0x00F0_00F0, 0xF in order, one per cycle.
- Flags 0000, then 1100 → two results with `out_illegal=1` and result=0. `retired_cnt` unchanged.
- Hold `out_ready=0` and stream 3 ops → `in_ready` goes 0 after 2 accepts. Raise `out_ready` → all 3 results emit in order with no loss and stable data while stalled.
- FULL state, assert `flush` together with `in_valid` → next cycle `out_valid=0`, `in_ready=1`, and the flushed-cycle input never appears.
- Force `retired_cnt` to 0xFFFF via 65535 legal ops → next legal emit wraps the count to 0x0000.

Source files
------------

// File: rtl/rv_alu_pkg.sv
// Shared types for the ALU execute stage: op encoding, the stored result entry
// and the one-hot decode-flag check.
package rv_alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_ILLEGAL
    } alu_op_e;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] result;
        logic [4:0]              rd;
        logic                    illegal;
    } alu_entry_t;

    // Anything other than exactly one asserted flag is illegal.
    function automatic alu_op_e flags_to_op(input logic f_add, input logic f_sub,
                                            input logic f_and, input logic f_or);
        alu_op_e op;
        case ({f_add, f_sub, f_and, f_or})
            4'b1000: op = ALU_ADD;
            4'b0100: op = ALU_SUB;
            4'b0010: op = ALU_AND;
            4'b0001: op = ALU_OR;
            default: op = ALU_ILLEGAL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_alu_exec_if.sv
// Decode-to-writeback bus of the ALU execute stage; master is the
// upstream/writeback side, slave is the execute stage itself.
interface rv_alu_exec_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic            is_add;
    logic            is_sub;
    logic            is_and;
    logic            is_or;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_addr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            out_illegal;

    modport master (
        output in_valid, is_add, is_sub, is_and, is_or, rs1_val, rs2_val, rd_addr, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_illegal
    );

    modport slave (
        input  in_valid, is_add, is_sub, is_and, is_or, rs1_val, rs2_val, rd_addr, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_illegal
    );
endinterface

// File: rtl/rv_skid_buffer.sv
// Two-entry valid/ready storage with a registered in_ready and an output register.
//   state | meaning
//   EMPTY | nothing held
//   ONE   | main register holds the oldest entry
//   FULL  | main holds oldest, skid holds the next one; in_ready low
module rv_skid_buffer #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_e;

    state_e state_q, state_d;
    T       main_q, main_d;
    T       skid_q, skid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept;
    logic   emit;

    assign accept = in_valid & in_ready_q;
    assign emit   = state_q[1] & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && emit) begin
                    main_d = in_data;
                end else if (accept) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (emit) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (emit) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush kills occupancy only; data registers keep their last value.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = state_q[1];
    assign out_data  = main_q;

endmodule

// File: rtl/rv_alu_exec.sv
// ALU execute stage: decodes one-hot flags, computes the result at accept time,
// buffers it in a two-entry skid buffer and counts legal retirements.
module rv_alu_exec
    import rv_alu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    rv_alu_exec_if.slave      bus,
    output logic [CNT_W-1:0]  retired_cnt
);

    alu_op_e          op;
    alu_entry_t       in_entry;
    alu_entry_t       out_entry;
    logic             out_valid;
    logic [CNT_W-1:0] retired_q, retired_d;

    always_comb begin
        op               = flags_to_op(bus.is_add, bus.is_sub, bus.is_and, bus.is_or);
        in_entry.rd      = bus.rd_addr;
        in_entry.illegal = 1'b0;
        case (op)
            ALU_ADD: in_entry.result = bus.rs1_val + bus.rs2_val;
            ALU_SUB: in_entry.result = bus.rs1_val - bus.rs2_val;
            ALU_AND: in_entry.result = bus.rs1_val & bus.rs2_val;
            ALU_OR:  in_entry.result = bus.rs1_val | bus.rs2_val;
            default: begin
                in_entry.result  = '0;
                in_entry.illegal = 1'b1;
            end
        endcase
    end

    rv_skid_buffer #(.T(alu_entry_t)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_entry)
    );

    assign bus.out_valid   = out_valid;
    assign bus.out_result  = out_entry.result;
    assign bus.out_rd      = out_entry.rd;
    assign bus.out_illegal = out_entry.illegal;

    // An emit coincident with flush is discarded, so it does not retire.
    always_comb begin
        retired_d = retired_q;
        if (out_valid && bus.out_ready && !out_entry.illegal && !flush) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired_cnt = retired_q;

endmodule

// File: tb/tb_rv_alu_exec.sv
// Directed bench for rv_alu_exec: ALU ops, illegal flags, backpressure,
// flush and retired-counter wrap, with hand-computed expectations.
module tb_rv_alu_exec;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] retired_cnt;
    int          checks;
    int          failures;

    rv_alu_exec_if #(.XLEN(32)) bus ();

    rv_alu_exec #(.XLEN(32), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus.slave),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] flags, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        bus.in_valid = v;
        {bus.is_add, bus.is_sub, bus.is_and, bus.is_or} = flags;
        bus.rs1_val  = a;
        bus.rs2_val  = b;
        bus.rd_addr  = rd;
    endtask

    task automatic check_out(input string tag, input logic [31:0] res, input logic [4:0] rd,
                             input logic ill);
        check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, "_result"}, bus.out_result, res);
        check({tag, "_rd"}, {27'd0, bus.out_rd}, {27'd0, rd});
        check({tag, "_illegal"}, {31'd0, bus.out_illegal}, {31'd0, ill});
    endtask

    localparam logic [3:0] F_ADD = 4'b1000;
    localparam logic [3:0] F_SUB = 4'b0100;
    localparam logic [3:0] F_AND = 4'b0010;
    localparam logic [3:0] F_OR  = 4'b0001;

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
        tick();
        tick();
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_result", bus.out_result, 32'd0);
        check("rst_rd", {27'd0, bus.out_rd}, 32'd0);
        check("rst_illegal", {31'd0, bus.out_illegal}, 32'd0);
        check("rst_cnt", {16'd0, retired_cnt}, 32'd0);
        rst = 1'b0;
        tick();

        // Back-to-back ops with writeback always ready
        bus.out_ready = 1'b1;
        drive(1'b1, F_ADD, 32'hFFFF_FFFF, 32'd1, 5'd5);
        tick();
        check_out("add_wrap", 32'h0, 5'd5, 1'b0);
        check("add_cnt_pre", {16'd0, retired_cnt}, 32'd0);
        drive(1'b1, F_SUB, 32'd3, 32'd5, 5'd1);
        tick();
        check_out("sub", 32'hFFFF_FFFE, 5'd1, 1'b0);
        check("cnt_after_add", {16'd0, retired_cnt}, 32'd1);
        drive(1'b1, F_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd2);
        tick();
        check_out("and", 32'h00F0_00F0, 5'd2, 1'b0);
        drive(1'b1, F_OR, 32'hA, 32'h5, 5'd3);
        tick();
        check_out("or", 32'hF, 5'd3, 1'b0);
        check("cnt_after_and", {16'd0, retired_cnt}, 32'd3);

        drive(1'b1, 4'b0000, 32'h1234, 32'h5678, 5'd7);
        tick();
        check_out("ill_none", 32'h0, 5'd7, 1'b1);
        check("cnt_after_or", {16'd0, retired_cnt}, 32'd4);
        drive(1'b1, 4'b1100, 32'h1234, 32'h5678, 5'd8);
        tick();
        check_out("ill_two", 32'h0, 5'd8, 1'b1);
        check("cnt_ill1", {16'd0, retired_cnt}, 32'd4);
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
        tick();
        check("drain_valid", {31'd0, bus.out_valid}, 32'd0);
        check("cnt_ill2", {16'd0, retired_cnt}, 32'd4);

        // Backpressure: three ops with writeback stalled
        bus.out_ready = 1'b0;
        drive(1'b1, F_ADD, 32'd1, 32'd2, 5'd1);
        tick();
        check_out("bp_a", 32'd3, 5'd1, 1'b0);
        check("bp_ready1", {31'd0, bus.in_ready}, 32'd1);
        drive(1'b1, F_ADD, 32'd10, 32'd20, 5'd2);
        tick();
        check("bp_ready2", {31'd0, bus.in_ready}, 32'd0);
        check_out("bp_hold1", 32'd3, 5'd1, 1'b0);
        drive(1'b1, F_ADD, 32'd100, 32'd200, 5'd3);
        tick();
        check("bp_ready3", {31'd0, bus.in_ready}, 32'd0);
        check_out("bp_hold2", 32'd3, 5'd1, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        check_out("bp_b", 32'd30, 5'd2, 1'b0);
        check("bp_ready4", {31'd0, bus.in_ready}, 32'd1);
        check("bp_cnt1", {16'd0, retired_cnt}, 32'd5);
        tick();
        check_out("bp_c", 32'd300, 5'd3, 1'b0);
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
        tick();
        check("bp_drain", {31'd0, bus.out_valid}, 32'd0);
        check("bp_cnt3", {16'd0, retired_cnt}, 32'd7);

        // Flush while FULL, with a same-cycle input that must be dropped
        bus.out_ready = 1'b0;
        drive(1'b1, F_ADD, 32'd1, 32'd1, 5'd4);
        tick();
        drive(1'b1, F_ADD, 32'd2, 32'd2, 5'd5);
        tick();
        check("fl_full", {31'd0, bus.in_ready}, 32'd0);
        flush = 1'b1;
        drive(1'b1, F_ADD, 32'd7, 32'd7, 5'd6);
        tick();
        check("fl_valid", {31'd0, bus.out_valid}, 32'd0);
        check("fl_ready", {31'd0, bus.in_ready}, 32'd1);
        flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
        tick();
        check("fl_still_empty", {31'd0, bus.out_valid}, 32'd0);
        drive(1'b1, F_ADD, 32'd5, 32'd5, 5'd9);
        tick();
        check_out("fl_next", 32'd10, 5'd9, 1'b0);
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
        tick();
        check("fl_cnt", {16'd0, retired_cnt}, 32'd8);

        // Counter wrap: 65527 more legal ops bring it to 0xFFFF
        drive(1'b1, F_OR, 32'd1, 32'd2, 5'd10);
        for (int i = 0; i < 65527; i++) begin
            tick();
        end
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
        tick();
        check("cnt_max", {16'd0, retired_cnt}, 32'h0000_FFFF);
        drive(1'b1, F_AND, 32'hFF, 32'h0F, 5'd11);
        tick();
        check_out("wrap_op", 32'h0F, 5'd11, 1'b0);
        drive(1'b0, 4'b0000, 32'd0, 32'd0, 5'd0);
        tick();
        check("cnt_wrap", {16'd0, retired_cnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
